// File: rtl/aes_key_stream_sink.sv
// ---------------------------------------------------------------------------
// aes_key_stream_sink
//
// Receiving end of the round-key stream from the compact AES key generator.
// One burst of NUM_KEYS keys (one per cycle) is captured into a register
// file. The stored schedule can then be replayed forward or in reverse over
// a valid/ready port. It can also be read at random through a combinational
// select port, so several round stages can share one key schedule.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rstn         : asynchronous active-low reset
//   key_valid_in : key strobe, high for NUM_KEYS consecutive cycles per burst
//   key_in       : key for the current strobe cycle (slot 0..NUM_KEYS-1)
//   flush        : synchronous clear of buffer state, flags and replay
//   keys_ready   : a complete burst is stored
//   err_short    : sticky, a burst ended before NUM_KEYS keys
//   err_overrun  : sticky, key_valid_in was seen during replay
//   rd_start     : replay request, accepted only in FULL
//   rd_reverse   : replay direction, sampled with an accepted rd_start
//   rd_valid     : replay word valid
//   rd_ready     : consumer accepts the replay word
//   rd_key       : replay key, mem[rd_idx]
//   rd_idx       : slot of rd_key
//   rd_last      : high with the final replay word
//   sel_idx      : random-access slot select
//   sel_key      : mem[sel_idx], or 0 when sel_idx >= NUM_KEYS
//   dbg_state    : current FSM state (EMPTY=0, FILL=1, FULL=2, REPLAY=3)
//
// Handshake: a replay word transfers on a rising edge where rd_valid and
// rd_ready are both 1. While rd_valid=1 and rd_ready=0, rd_key, rd_idx and
// rd_last hold steady, with no timeout. rd_valid is never withdrawn before
// the transfer completes, except by flush or reset.
// ---------------------------------------------------------------------------
module aes_key_stream_sink #(
    parameter int NUM_KEYS = 10,
    parameter int KEY_W    = 128,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             key_valid_in,
    input  logic [KEY_W-1:0] key_in,
    input  logic             flush,
    output logic             keys_ready,
    output logic             err_short,
    output logic             err_overrun,
    input  logic             rd_start,
    input  logic             rd_reverse,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [KEY_W-1:0] rd_key,
    output logic [IDX_W-1:0] rd_idx,
    output logic             rd_last,
    input  logic [IDX_W-1:0] sel_idx,
    output logic [KEY_W-1:0] sel_key,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FILL   = 2'd1,
        ST_FULL   = 2'd2,
        ST_REPLAY = 2'd3
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    state_e           state_q;
    logic [IDX_W-1:0] wr_ptr_q;
    logic [IDX_W-1:0] rd_ptr_q;
    logic [IDX_W-1:0] rd_ptr_d;
    logic             rd_rev_q;
    logic             keys_ready_q;
    logic             err_short_q;
    logic             err_overrun_q;
    logic             rd_valid_q;
    logic             rd_last_q;

    logic [KEY_W-1:0] mem_q [NUM_KEYS];

    // Write port. A strobe in EMPTY or FULL starts a new burst at slot 0.
    // In FILL the strobe continues at wr_ptr. A strobe in REPLAY, or in a
    // flush cycle, never writes.
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (!flush && key_valid_in) begin
            case (state_q)
                ST_EMPTY, ST_FULL: begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                end
                ST_FILL: begin
                    wr_en   = 1'b1;
                    wr_addr = wr_ptr_q;
                end
                default: begin
                    wr_en   = 1'b0;
                    wr_addr = '0;
                end
            endcase
        end
    end

    // The key memory has no reset, so its contents survive rstn and flush.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= key_in;
        end
    end

    // Next replay slot after a transfer. Replay never wraps.
    always_comb begin
        rd_ptr_d = rd_rev_q ? (rd_ptr_q - IDX_W'(1)) : (rd_ptr_q + IDX_W'(1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_EMPTY;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_rev_q      <= 1'b0;
            keys_ready_q  <= 1'b0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
        end else if (flush) begin
            state_q       <= ST_EMPTY;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            keys_ready_q  <= 1'b0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY, ST_FILL, ST_FULL: begin
                    if (wr_en) begin
                        // The write to the last slot completes the burst.
                        // keys_ready is registered, so it shows one cycle
                        // after that final key.
                        if (wr_addr == LAST_IDX) begin
                            state_q      <= ST_FULL;
                            wr_ptr_q     <= '0;
                            keys_ready_q <= 1'b1;
                        end else begin
                            state_q      <= ST_FILL;
                            wr_ptr_q     <= wr_addr + IDX_W'(1);
                            keys_ready_q <= 1'b0;
                        end
                    end else if (state_q == ST_FILL) begin
                        // The strobe dropped before the burst was complete.
                        state_q     <= ST_EMPTY;
                        wr_ptr_q    <= '0;
                        err_short_q <= 1'b1;
                    end else if (state_q == ST_FULL && rd_start) begin
                        state_q    <= ST_REPLAY;
                        rd_rev_q   <= rd_reverse;
                        rd_ptr_q   <= rd_reverse ? LAST_IDX : '0;
                        rd_valid_q <= 1'b1;
                        // With a single slot, the first word is also the last.
                        rd_last_q  <= (LAST_IDX == '0);
                    end
                end
                ST_REPLAY: begin
                    if (key_valid_in) begin
                        err_overrun_q <= 1'b1;
                    end
                    if (rd_ready) begin
                        if (rd_last_q) begin
                            state_q    <= ST_FULL;
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                        end else begin
                            rd_ptr_q  <= rd_ptr_d;
                            rd_last_q <= rd_rev_q ? (rd_ptr_d == '0)
                                                  : (rd_ptr_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign keys_ready  = keys_ready_q;
    assign err_short   = err_short_q;
    assign err_overrun = err_overrun_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign rd_idx      = rd_ptr_q;
    assign rd_key      = mem_q[rd_ptr_q];
    assign sel_key     = (sel_idx <= LAST_IDX) ? mem_q[sel_idx] : '0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_aes_key_stream_sink.sv
// ---------------------------------------------------------------------------
// tb_aes_key_stream_sink
//
// Directed bench for aes_key_stream_sink. Inputs are driven on the falling
// clock edge and outputs are sampled on the falling edge. Expected keys come
// from a local copy of what the bench has written into each slot.
// ---------------------------------------------------------------------------
module tb_aes_key_stream_sink;

    localparam int NUM_KEYS = 10;
    localparam int KEY_W    = 128;
    localparam int IDX_W    = 4;

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_FULL   = 2'd2;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rstn;
    logic             key_valid_in;
    logic [KEY_W-1:0] key_in;
    logic             flush;
    logic             keys_ready;
    logic             err_short;
    logic             err_overrun;
    logic             rd_start;
    logic             rd_reverse;
    logic             rd_valid;
    logic             rd_ready;
    logic [KEY_W-1:0] rd_key;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_last;
    logic [IDX_W-1:0] sel_idx;
    logic [KEY_W-1:0] sel_key;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    aes_key_stream_sink #(
        .NUM_KEYS(NUM_KEYS),
        .KEY_W   (KEY_W),
        .IDX_W   (IDX_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_valid_in(key_valid_in),
        .key_in      (key_in),
        .flush       (flush),
        .keys_ready  (keys_ready),
        .err_short   (err_short),
        .err_overrun (err_overrun),
        .rd_start    (rd_start),
        .rd_reverse  (rd_reverse),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_key      (rd_key),
        .rd_idx      (rd_idx),
        .rd_last     (rd_last),
        .sel_idx     (sel_idx),
        .sel_key     (sel_key),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int               tests_run    = 0;
    int               tests_failed = 0;
    logic [KEY_W-1:0] exp_mem [NUM_KEYS];

    task automatic check(input string tag, input logic [KEY_W-1:0] obs,
                         input logic [KEY_W-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Key pattern: byte v repeated 16 times.
    function automatic logic [KEY_W-1:0] kval(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {16{b}};
    endfunction

    // ---------------- driver tasks ----------------
    // Drives n consecutive keys kval(off+i) into slots 0..n-1. The task
    // returns at the falling edge after the last key edge, with the strobe
    // already dropped.
    task automatic send_burst(input int n, input int off);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == NUM_KEYS - 1) check("kr_before_last", keys_ready, 0);
            key_valid_in = 1'b1;
            key_in       = kval(off + i);
            exp_mem[i]   = kval(off + i);
        end
        @(negedge clk);
        key_valid_in = 1'b0;
        key_in       = '0;
    endtask

    // Full replay from FULL. toggle alternates rd_ready 1,0,1,0...
    // When ovr_at >= 0, a full junk burst is driven while word ovr_at is
    // presented, with rd_ready held low.
    task automatic replay(input bit rev, input bit toggle, input int ovr_at);
        int w;
        int cyc;
        int exp_i;
        int ovr_cnt;
        bit rdy;
        w       = 0;
        cyc     = 0;
        ovr_cnt = 0;
        rdy     = 1'b1;
        @(negedge clk);
        rd_start   = 1'b1;
        rd_reverse = rev;
        @(negedge clk);
        rd_start   = 1'b0;
        rd_reverse = 1'b0;
        while (w < NUM_KEYS && cyc < 60) begin
            exp_i = rev ? (NUM_KEYS - 1 - w) : w;
            check("rd_valid", rd_valid, 1);
            check("rd_idx", rd_idx, exp_i);
            check("rd_key", rd_key, exp_mem[exp_i]);
            check("rd_last", rd_last, (w == NUM_KEYS - 1));
            check("kr_in_replay", keys_ready, 1);
            if (w == ovr_at && ovr_cnt < NUM_KEYS) begin
                key_valid_in = 1'b1;
                key_in       = kval(8'hA0 + ovr_cnt);
                rd_ready     = 1'b0;
                ovr_cnt++;
            end else begin
                key_valid_in = 1'b0;
                key_in       = '0;
                rd_ready     = rdy;
                if (rdy) w++;
                if (toggle) rdy = ~rdy;
            end
            @(negedge clk);
            cyc++;
        end
        key_valid_in = 1'b0;
        check("replay_words", w, NUM_KEYS);
        check("rd_valid_after", rd_valid, 0);
        check("rd_last_after", rd_last, 0);
        check("state_after_replay", dbg_state, S_FULL);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn         = 1'b0;
        key_valid_in = 1'b0;
        key_in       = '0;
        flush        = 1'b0;
        rd_start     = 1'b0;
        rd_reverse   = 1'b0;
        rd_ready     = 1'b0;
        sel_idx      = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_keys_ready", keys_ready, 0);
        check("rst_err_short", err_short, 0);
        check("rst_err_overrun", err_overrun, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_rd_idx", rd_idx, 0);
        check("rst_state", dbg_state, S_EMPTY);
        rstn = 1'b1;

        // Burst K0..K9 = 0101..01 * (i+1)
        send_burst(NUM_KEYS, 1);
        check("kr_after_last", keys_ready, 1);
        check("state_full", dbg_state, S_FULL);
        for (int i = 0; i < NUM_KEYS; i++) begin
            sel_idx = IDX_W'(i);
            #1;
            check("sel_sweep", sel_key, kval(i + 1));
        end
        sel_idx = 4'd12;
        #1;
        check("sel_out_of_range", sel_key, 0);

        // Forward replay with backpressure, then reverse replay twice
        replay(1'b0, 1'b1, -1);
        replay(1'b1, 1'b0, -1);
        replay(1'b1, 1'b0, -1);
        check("no_overrun_yet", err_overrun, 0);

        // Overrun during replay at word 3
        replay(1'b0, 1'b0, 3);
        check("err_overrun", err_overrun, 1);
        check("keys_ready_after_ovr", keys_ready, 1);

        // Short burst: 6 keys, then the strobe drops
        send_burst(6, 16);
        check("short_kr_drop", keys_ready, 0);
        @(negedge clk);
        check("err_short", err_short, 1);
        check("short_keys_ready", keys_ready, 0);
        check("short_state", dbg_state, S_EMPTY);

        // A following full burst; the sticky flags stay set
        send_burst(NUM_KEYS, 32);
        check("kr_after_refill", keys_ready, 1);
        check("err_short_sticky", err_short, 1);
        check("err_overrun_sticky", err_overrun, 1);
        sel_idx = 4'd7;
        #1;
        check("sel_refill", sel_key, kval(39));

        // Flush mid-FILL on slot 4; the slot-4 write is dropped
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            key_valid_in = 1'b1;
            key_in       = kval(64 + i);
            flush        = (i == 4);
            if (i < 4) exp_mem[i] = kval(64 + i);
        end
        @(negedge clk);
        key_valid_in = 1'b0;
        flush        = 1'b0;
        rd_start     = 1'b1;
        check("flush_keys_ready", keys_ready, 0);
        check("flush_rd_valid", rd_valid, 0);
        check("flush_err_short", err_short, 0);
        check("flush_err_overrun", err_overrun, 0);
        check("flush_state", dbg_state, S_EMPTY);
        sel_idx = 4'd4;
        #1;
        check("flush_slot4_kept", sel_key, exp_mem[4]);
        sel_idx = 4'd3;
        #1;
        check("flush_slot3_new", sel_key, kval(67));
        @(negedge clk);
        rd_start = 1'b0;
        check("rd_start_ignored", rd_valid, 0);

        // Async reset mid-replay, while the last word is presented
        send_burst(NUM_KEYS, 96);
        check("kr_before_reset", keys_ready, 1);
        @(negedge clk);
        rd_start   = 1'b1;
        rd_reverse = 1'b0;
        rd_ready   = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (NUM_KEYS - 1) @(negedge clk);
        rd_ready = 1'b0;
        check("pre_rst_rd_last", rd_last, 1);
        check("pre_rst_rd_key", rd_key, kval(105));
        #2;
        rstn = 1'b0;
        #1;
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_last", rd_last, 0);
        check("arst_keys_ready", keys_ready, 0);
        check("arst_rd_idx", rd_idx, 0);
        check("arst_state", dbg_state, S_EMPTY);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/aes_key_stream_sink.md
Name: aes_key_stream_sink

Overview:
- Receiving end of the round-key stream produced by the compact AES key generator.
- Captures one burst of NUM_KEYS keys, one per cycle, into a register file.
- Replays the keys in forward or reverse order through a valid/ready handshake.
- Offers a combinational random-access read port so several AES round stages in explode/implode can share one key schedule.

Parameters:
NUM_KEYS, 10, keys per burst (AES-256 CryptoNight round keys)
KEY_W, 128, key width in bits
IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_KEYS

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
key_valid_in  in  1  key strobe from generator; high for exactly NUM_KEYS consecutive cycles per burst
key_in  in  KEY_W  key for the current strobe cycle; burst order slot 0..NUM_KEYS-1
flush  in  1  synchronous clear of buffer, flags and replay
keys_ready  out  1  full burst stored, contents valid
err_short  out  1  sticky: burst ended before NUM_KEYS keys
err_overrun  out  1  sticky: key_valid_in seen during REPLAY
rd_start  in  1  request replay; accepted only in FULL
rd_reverse  in  1  sampled with an accepted rd_start; 1 = slot NUM_KEYS-1 down to 0
rd_valid  out  1  replay word valid
rd_ready  in  1  consumer accepts word
rd_key  out  KEY_W  replay key = mem[rd_idx]
rd_idx  out  IDX_W  slot of rd_key
rd_last  out  1  high with the final replay word
sel_idx  in  IDX_W  random-access slot select
sel_key  out  KEY_W  mem[sel_idx], combinational; 0 if sel_idx >= NUM_KEYS

Behaviour:
- Reset (rstn=0, asynchronous):
  - State EMPTY; all pointers 0.
  - keys_ready, err_short, err_overrun, rd_valid and rd_last are 0; rd_idx is 0.
  - The key memory is not reset.
- States and transitions:
  - EMPTY: key_valid_in writes key_in to slot 0, wr_ptr<=1, go to FILL.
  - FILL, key_valid_in=1: writes slot wr_ptr and increments wr_ptr. On the write to slot NUM_KEYS-1, go to FULL; keys_ready rises on the following cycle.
  - FILL, key_valid_in=0: set err_short, go to EMPTY; partial contents discarded.
  - FULL, key_valid_in=1: a new burst. keys_ready<=0, slot 0 written, wr_ptr<=1, go to FILL.
  - FULL, rd_start=1 (no key_valid_in): latch rd_reverse, rd_ptr<=0 (forward) or NUM_KEYS-1 (reverse), go to REPLAY. rd_valid rises the next cycle.
  - FULL, key_valid_in and rd_start together: key_valid_in wins and rd_start is dropped.
  - REPLAY: rd_valid=1, rd_idx=rd_ptr. Each rd_valid&rd_ready cycle steps rd_ptr by ±1.
  - REPLAY: rd_last=1 while rd_ptr is the final slot (NUM_KEYS-1 forward, 0 reverse). A transfer with rd_last set returns to FULL; rd_valid=0 next cycle.
  - REPLAY, key_valid_in=1: ignored, memory unchanged, err_overrun set.
- rd_start outside FULL is ignored with no flag.
- keys_ready stays 1 through REPLAY. Replay can be repeated any number of times from FULL.
- rd_ready low holds rd_key/rd_idx stable, with no timeout.
- flush has priority over every other input:
  - Next state EMPTY.
  - keys_ready, rd_valid and both error flags cleared.
  - A key_valid_in in the flush cycle is discarded.
- Throughput and latency:
  - Capture takes one key per cycle, NUM_KEYS cycles per burst.
  - keys_ready rises 1 cycle after the last key.
  - Replay delivers one word per cycle while rd_ready=1, with the first word 1 cycle after rd_start.
- sel_key:
  - Pure mux on mem, valid whenever keys_ready=1.
  - During FILL, slots below wr_ptr already hold the new burst and higher slots still hold the previous burst.
- Only pointer arithmetic is used: wr_ptr never exceeds NUM_KEYS-1 and rd_ptr never wraps.

Test Plan:
- Burst test:
  - Stimulus: burst with Ki = 128'h0101…01 × (i+1), i=0..9.
  - Response: keys_ready=1 exactly 1 cycle after K9. sel_idx sweep 0..9 returns K0..K9; sel_idx=12 returns 0.
- Forward replay with backpressure:
  - Stimulus: rd_reverse=0, rd_ready toggled 1,0,1,0…
  - Response: rd_key sequence K0..K9 with rd_idx 0..9, each held stable while rd_ready=0. rd_last only with K9, then state FULL and rd_valid=0.
- Reverse replay:
  - Stimulus: rd_reverse=1 with rd_ready=1.
  - Response: K9..K0 on 10 consecutive cycles, rd_last with K0. A second rd_start reproduces the same sequence.
- Short burst:
  - Stimulus: key_valid_in drops after 6 keys.
  - Response: err_short=1, keys_ready=0, state EMPTY. A following full burst sets keys_ready=1 and err_short stays 1 until flush.
- Overrun during replay:
  - Stimulus: burst during REPLAY at word 3.
  - Response: err_overrun=1 and the replay still outputs the original K0..K9.
- Flush and async reset:
  - Stimulus: flush asserted mid-FILL (slot 4).
  - Response: next cycle keys_ready=0 and rd_valid=0, with no slot-4 write visible as valid.
  - Stimulus: rstn pulsed low mid-REPLAY.
  - Response: rd_valid, rd_last and keys_ready go to 0 immediately, without a clock edge.
